// File: rtl/rf_dump_reader_if.sv
// Entry stream carrying one (register index, register contents) pair per handshake.
interface rf_dump_reader_if;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/rf_dump_reader.sv
// Walks a register file read port from index 0 to LAST_ADDR and emits each entry
// over a valid/ready stream, optionally dropping registers that read zero.
module rf_dump_reader #(
    parameter int         SKIP_ZERO = 1,
    parameter logic [4:0] LAST_ADDR = 5'd31
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic [4:0]               rf_addr,
    input  logic [31:0]              rf_data,
    rf_dump_reader_if.master         entry,
    output logic                     busy,
    output logic                     done,
    output logic [5:0]               sent_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [4:0]  addr_q;
    logic        valid_q;
    logic [31:0] data_q;
    logic        skip;
    logic        handshake;

    assign skip      = (SKIP_ZERO != 0) && (rf_data == '0);
    assign handshake = valid_q && entry.out_ready;

    assign entry.out_valid = valid_q;
    assign entry.out_addr  = addr_q;
    assign entry.out_data  = data_q;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rf_addr  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            sent_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rf_addr  <= '0;
                        sent_cnt <= '0;
                        state    <= S_READ;
                    end
                end

                S_READ: begin
                    data_q <= rf_data;
                    addr_q <= rf_addr;
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (skip) begin
                        // Skipped entries advance in place; the last index ends the scan
                        // so rf_addr never passes LAST_ADDR.
                        if (rf_addr == LAST_ADDR) begin
                            state <= S_DONE;
                        end else begin
                            rf_addr <= rf_addr + 5'd1;
                        end
                    end else begin
                        valid_q <= 1'b1;
                        state   <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (handshake) begin
                        sent_cnt <= sent_cnt + 6'd1;
                        valid_q  <= 1'b0;
                    end
                    // Abort wins over the next-address step but a concurrent handshake
                    // has already been counted above.
                    if (abort) begin
                        valid_q <= 1'b0;
                        state   <= S_IDLE;
                    end else if (handshake) begin
                        if (addr_q == LAST_ADDR) begin
                            state <= S_DONE;
                        end else begin
                            rf_addr <= addr_q + 5'd1;
                            state   <= S_READ;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
